spi_slave: RTL and testbench
============================

Name: spi_slave

Overview:
- SPI mode-0 peripheral (CPOL=0, CPHA=0, MSB first, 8-bit frames). It is the responder end of the link our SPI master drives.
- Oversamples SCLK, SCE and MOSI on the system clock.
- Shifts received bytes out to the core over a RecvAdv/RecvAck handshake.
- Takes transmit bytes from the core over a SendReq/SendAck handshake.
- Supports back-to-back bytes while SCE stays low, which is how the master streams.

Parameters:
- SYNC_STAGES, 2, synchroniser depth on SCLK/SCE/MOSI; legal range 2..3.
- IDLE_FILL, 8'hFF, byte shifted out on MISO when the core has no SendReq pending.

Ports:
- Clk  input  1  system clock; must be at least 8x the SCLK frequency.
- nReset  input  1  asynchronous, active-low reset.
- SCLK  input  1  SPI clock from the master; asynchronous to Clk.
- SCE  input  1  chip enable from the master, active low; asynchronous.
- MOSI  input  1  serial data from the master; asynchronous.
- MISO  output  1  serial data to the master; driven 1 when deselected.
- SendData  input  8  next transmit byte; must be stable while SendReq=1.
- SendReq  input  1  core has a transmit byte; level.
- SendAck  output  1  one-Clk pulse when SendData has been captured.
- RecvData  output  8  last complete received byte.
- RecvAdv  output  1  a new byte is present; held until RecvAck.
- RecvAck  input  1  core has consumed RecvData.
- Overrun  output  1  present only with SPI_SLAVE_OVERRUN_EN.

Behaviour:
- Reset (nReset=0, async) sets:
  - MISO=1, SendAck=0, RecvData=8'h00, RecvAdv=0, Overrun=0;
  - tx shift register = IDLE_FILL, rx shift register = 0, bit counter = 0;
  - state = IDLE; synchroniser flops preset to SCLK=0, SCE=1, MOSI=1.
- Synchronisers and edge detection:
  - Each input passes through SYNC_STAGES flops.
  - Edge detect compares the synchronised value with a one-Clk-delayed copy.
  - An action is taken SYNC_STAGES+1 Clk after the pin change.
- State IDLE (SCE_s=1):
  - MISO=1, bit counter held at 0, SCLK edges ignored.
  - On falling edge of SCE_s, go to ACTIVE and load a byte (load rule below) in the same cycle.
- Load rule:
  - If SendReq=1: tx register ← SendData and SendAck=1 for exactly one Clk.
  - Otherwise: tx register ← IDLE_FILL and no SendAck.
  - In both cases MISO ← bit 7 of the loaded value.
- State ACTIVE, rising edge of SCLK_s:
  - rx register ← {rx[6:0], MOSI_s}; bit counter +1.
  - On the 8th rise (counter 7→0, wraps): RecvData ← completed byte and RecvAdv=1 on the next Clk.
- State ACTIVE, falling edge of SCLK_s:
  - If the bit counter is 0 (byte boundary), apply the load rule. This gives back-to-back streaming with no gap.
  - Otherwise: tx ← {tx[6:0], 0} and MISO ← new tx[7].
- Rising edge of SCE_s while ACTIVE:
  - Abort and return to IDLE; MISO=1 on the next Clk.
  - A partial rx byte is discarded: no RecvAdv, counter reset.
  - A tx byte already loaded is lost; its SendAck has already been given.
- RecvAck:
  - RecvAck=1 clears RecvAdv on the next Clk.
  - If a byte completes in the same Clk as RecvAck, completion wins: RecvAdv stays 1 and RecvData is updated.
- A byte completing while RecvAdv=1 and no RecvAck overwrites RecvData; RecvAdv stays 1.
- Simultaneous SCE falling and SCLK rising in the same synchronised cycle: the SCE load happens first, then the rise is processed in the following Clk. Use a pending flag.
- Reset mid-frame: immediate return to the reset values above; the frame is lost.

Optional Feature:
- Macro SPI_SLAVE_OVERRUN_EN.
- Defined:
  - Output Overrun exists.
  - It becomes sticky 1 when a byte completes while RecvAdv=1 and RecvAck=0 in that Clk.
  - It clears together with RecvAdv on RecvAck, unless a new overrun occurs in the same Clk.
  - Data overwrite behaviour is unchanged.
- Undefined: no Overrun port or logic; overwrite is silent.

Test Plan:
- Byte exchange:
  - Stimulus: Clk=50 MHz, SCLK=5 MHz; SendReq=1 with SendData=8'hA5 before SCE falls; master sends 8'h3C.
  - Required: MISO bits 1,0,1,0,0,1,0,1 on successive rises; one SendAck pulse at SCE fall; RecvData=8'h3C with RecvAdv=1 after the 8th rise.
- No transmit data:
  - Stimulus: SendReq=0 for the whole frame; master sends 8'h00.
  - Required: MISO=1 on all 8 rises (8'hFF); SendAck never asserted; RecvData=8'h00.
- Streaming:
  - Stimulus: SCE held low for 3 bytes; master sends 8'h01, 8'h80, 8'hFF; core feeds 8'h11, 8'h22, 8'h33 using SendAck.
  - Required: 3 RecvAdv events with RecvData in order; MISO carries 8'h11, 8'h22, 8'h33; no bit slip.
- Abort:
  - Stimulus: SCE rises after 5 rises.
  - Required: no RecvAdv; MISO=1 within SYNC_STAGES+2 Clk; the next frame receives 8'h5A correctly.
- Overrun (macro defined):
  - Stimulus: RecvAck held 0 across 2 bytes, 8'h12 then 8'h34.
  - Required: RecvData=8'h34 and Overrun=1; one RecvAck pulse clears both RecvAdv and Overrun.
- Reset mid-frame:
  - Stimulus: nReset pulsed low after 3 rises.
  - Required: all outputs take their reset values asynchronously; the next full frame works normally.

Source files
------------

// File: rtl/spi_slave.sv
// SPI mode-0 responder: oversampled SCLK/SCE/MOSI, byte-wide receive and transmit handshakes.
// Optional sticky overrun flag is built when SPI_SLAVE_OVERRUN_EN is defined.
`timescale 1ns/1ps
module spi_slave #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_FILL   = 8'hFF
) (
    input  logic       Clk,
    input  logic       nReset,
    input  logic       SCLK,
    input  logic       SCE,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [7:0] SendData,
    input  logic       SendReq,
    output logic       SendAck,
    output logic [7:0] RecvData,
    output logic       RecvAdv,
    input  logic       RecvAck
`ifdef SPI_SLAVE_OVERRUN_EN
    ,
    output logic       Overrun
`endif
);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic [SYNC_STAGES-1:0] sce_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sclk_d_r;
    logic                   sce_d_r;

    state_t     state_r;
    logic [6:0] tx_r;
    logic [6:0] rx_r;
    logic [2:0] cnt_r;
    logic       rise_pend_r;
    logic       miso_r;
    logic       send_ack_r;
    logic [7:0] recv_data_r;
    logic       recv_adv_r;

    logic       sclk_s;
    logic       sce_s;
    logic       mosi_s;
    logic       sclk_rise_s;
    logic       sclk_fall_s;
    logic       sce_fall_s;
    logic       sce_rise_s;
    logic       rise_evt_s;
    logic       byte_done_s;
    logic [7:0] load_val_s;

    // Input synchronisers and one-cycle delayed copies for edge detection.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            sce_sync_r  <= {SYNC_STAGES{1'b1}};
            mosi_sync_r <= {SYNC_STAGES{1'b1}};
            sclk_d_r    <= 1'b0;
            sce_d_r     <= 1'b1;
        end else begin
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], SCLK};
            sce_sync_r  <= {sce_sync_r[SYNC_STAGES-2:0], SCE};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
            sclk_d_r    <= sclk_s;
            sce_d_r     <= sce_s;
        end
    end

    assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
    assign sce_s       = sce_sync_r[SYNC_STAGES-1];
    assign mosi_s      = mosi_sync_r[SYNC_STAGES-1];
    assign sclk_rise_s = sclk_s & ~sclk_d_r;
    assign sclk_fall_s = ~sclk_s & sclk_d_r;
    assign sce_fall_s  = ~sce_s & sce_d_r;
    assign sce_rise_s  = sce_s & ~sce_d_r;

    // A rise coinciding with SCE fall is deferred one cycle through rise_pend_r.
    assign rise_evt_s  = sclk_rise_s | rise_pend_r;
    assign byte_done_s = (state_r == ST_ACTIVE) && !sce_rise_s && rise_evt_s && (cnt_r == 3'd7);
    assign load_val_s  = SendReq ? SendData : IDLE_FILL;

    // Frame FSM: tx/rx shifting, byte-boundary loads and abort handling.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_r     <= ST_IDLE;
            tx_r        <= IDLE_FILL[6:0];
            rx_r        <= 7'h00;
            cnt_r       <= 3'd0;
            rise_pend_r <= 1'b0;
            miso_r      <= 1'b1;
            send_ack_r  <= 1'b0;
        end else begin
            send_ack_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    miso_r      <= 1'b1;
                    cnt_r       <= 3'd0;
                    rise_pend_r <= 1'b0;
                    if (sce_fall_s) begin
                        state_r     <= ST_ACTIVE;
                        tx_r        <= load_val_s[6:0];
                        miso_r      <= load_val_s[7];
                        send_ack_r  <= SendReq;
                        rise_pend_r <= sclk_rise_s;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ACTIVE: begin
                    if (sce_rise_s) begin
                        state_r     <= ST_IDLE;
                        miso_r      <= 1'b1;
                        cnt_r       <= 3'd0;
                        rx_r        <= 7'h00;
                        rise_pend_r <= 1'b0;
                    end else if (rise_evt_s) begin
                        rx_r        <= {rx_r[5:0], mosi_s};
                        cnt_r       <= cnt_r + 3'd1;
                        rise_pend_r <= 1'b0;
                    end else if (sclk_fall_s) begin
                        if (cnt_r == 3'd0) begin
                            tx_r       <= load_val_s[6:0];
                            miso_r     <= load_val_s[7];
                            send_ack_r <= SendReq;
                        end else begin
                            tx_r   <= {tx_r[5:0], 1'b0};
                            miso_r <= tx_r[6];
                        end
                    end else begin
                        state_r <= ST_ACTIVE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    miso_r      <= 1'b1;
                    cnt_r       <= 3'd0;
                    rise_pend_r <= 1'b0;
                end
            endcase
        end
    end

    // Receive handshake: a completing byte takes priority over the acknowledge.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            recv_data_r <= 8'h00;
            recv_adv_r  <= 1'b0;
        end else if (byte_done_s) begin
            recv_data_r <= {rx_r, mosi_s};
            recv_adv_r  <= 1'b1;
        end else if (RecvAck) begin
            recv_adv_r  <= 1'b0;
        end else begin
            recv_adv_r  <= recv_adv_r;
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic overrun_r;

    // Sticky overrun: set when an unacknowledged byte is overwritten.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            overrun_r <= 1'b0;
        end else if (byte_done_s && recv_adv_r && !RecvAck) begin
            overrun_r <= 1'b1;
        end else if (RecvAck) begin
            overrun_r <= 1'b0;
        end else begin
            overrun_r <= overrun_r;
        end
    end

    assign Overrun = overrun_r;
`endif

    assign MISO     = miso_r;
    assign SendAck  = send_ack_r;
    assign RecvData = recv_data_r;
    assign RecvAdv  = recv_adv_r;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: vector table of single-byte frames plus streaming,
// coincident-edge, abort, overwrite/overrun and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_spi_slave;

    localparam int HALF = 100;

    logic       Clk = 1'b0;
    logic       nReset = 1'b0;
    logic       SCLK = 1'b0;
    logic       SCE = 1'b1;
    logic       MOSI = 1'b1;
    logic       MISO;
    logic [7:0] SendData = 8'h00;
    logic       SendReq = 1'b0;
    logic       SendAck;
    logic [7:0] RecvData;
    logic       RecvAdv;
    logic       RecvAck = 1'b0;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic       Overrun;
`endif

    spi_slave #(.SYNC_STAGES(2), .IDLE_FILL(8'hFF)) dut (
        .Clk(Clk), .nReset(nReset), .SCLK(SCLK), .SCE(SCE), .MOSI(MOSI), .MISO(MISO),
        .SendData(SendData), .SendReq(SendReq), .SendAck(SendAck),
        .RecvData(RecvData), .RecvAdv(RecvAdv), .RecvAck(RecvAck)
`ifdef SPI_SLAVE_OVERRUN_EN
        , .Overrun(Overrun)
`endif
    );

    always #10 Clk = ~Clk;

    typedef struct {
        logic       req;
        logic [7:0] sdata;
        logic [7:0] mosi;
        logic [7:0] exp_miso;
        logic [7:0] exp_recv;
        int         exp_acks;
    } vec_t;

    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         ack_cnt = 0;
    int         adv_cnt = 0;
    int         ack_req_cnt = 0;
    int         ack_done_cnt = 0;
    logic       auto_ack = 1'b1;
    logic       prev_adv = 1'b0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_log[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic spi_bits(input logic [7:0] mb, input int nbits, output logic [7:0] sb);
        sb = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            MOSI = mb[7-i];
            #(HALF);
            SCLK = 1'b1;
            sb[7-i] = MISO;
            #(HALF);
            SCLK = 1'b0;
        end
    endtask

    task automatic frame_start();
        @(posedge Clk);
        #3;
        SCE = 1'b0;
    endtask

    task automatic frame_end();
        #(HALF);
        SCE = 1'b1;
        #(4*HALF);
    endtask

    // Core model: feeds the transmit queue on SendAck, logs and acknowledges received bytes.
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (SendAck) begin
                ack_cnt++;
                SendReq = 1'b0;
            end
            if (!SendReq && tx_q.size() > 0) begin
                SendData = tx_q.pop_front();
                SendReq  = 1'b1;
            end
            if (RecvAdv && !prev_adv) begin
                adv_cnt++;
                rx_log.push_back(RecvData);
            end
            prev_adv = RecvAdv;
            if (RecvAck) RecvAck = 1'b0;
            else if (auto_ack && RecvAdv) RecvAck = 1'b1;
            else if (ack_req_cnt != ack_done_cnt) begin
                RecvAck = 1'b1;
                ack_done_cnt++;
            end
        end
    end

    initial begin
        vec_t       vecs[4];
        logic [7:0] got;
        int         a0;
        int         n0;

        vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1};
        vecs[1] = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'h00, 0};
        vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 1};
        vecs[3] = '{1'b1, 8'hC3, 8'h81, 8'hC3, 8'h81, 1};

        #25;
        chk("rst_miso", {31'd0, MISO}, 32'd1);
        chk("rst_sendack", {31'd0, SendAck}, 32'd0);
        chk("rst_recvdata", {24'd0, RecvData}, 32'h00);
        chk("rst_recvadv", {31'd0, RecvAdv}, 32'd0);
        #20;
        nReset = 1'b1;
        repeat (5) @(posedge Clk);

        for (int i = 0; i < 4; i++) begin
            if (vecs[i].req) tx_q.push_back(vecs[i].sdata);
            repeat (3) @(posedge Clk);
            a0 = ack_cnt;
            n0 = adv_cnt;
            frame_start();
            spi_bits(vecs[i].mosi, 8, got);
            frame_end();
            chk($sformatf("vec%0d_miso", i), {24'd0, got}, {24'd0, vecs[i].exp_miso});
            chk($sformatf("vec%0d_advs", i), adv_cnt - n0, 32'd1);
            chk($sformatf("vec%0d_recv", i), {24'd0, rx_log[$]}, {24'd0, vecs[i].exp_recv});
            chk($sformatf("vec%0d_acks", i), ack_cnt - a0, vecs[i].exp_acks);
        end

        // Streaming: three bytes under one SCE low period.
        tx_q.push_back(8'h11);
        tx_q.push_back(8'h22);
        tx_q.push_back(8'h33);
        repeat (3) @(posedge Clk);
        a0 = ack_cnt;
        n0 = adv_cnt;
        frame_start();
        spi_bits(8'h01, 8, got);
        chk("stream_miso0", {24'd0, got}, 32'h11);
        spi_bits(8'h80, 8, got);
        chk("stream_miso1", {24'd0, got}, 32'h22);
        spi_bits(8'hFF, 8, got);
        chk("stream_miso2", {24'd0, got}, 32'h33);
        frame_end();
        chk("stream_advs", adv_cnt - n0, 32'd3);
        chk("stream_acks", ack_cnt - a0, 32'd3);
        chk("stream_rx0", {24'd0, rx_log[rx_log.size()-3]}, 32'h01);
        chk("stream_rx1", {24'd0, rx_log[rx_log.size()-2]}, 32'h80);
        chk("stream_rx2", {24'd0, rx_log[rx_log.size()-1]}, 32'hFF);

        // SCE fall and first SCLK rise in the same instant.
        n0 = adv_cnt;
        @(posedge Clk);
        #3;
        MOSI = 1'b1;
        SCE  = 1'b0;
        SCLK = 1'b1;
        #(HALF);
        SCLK = 1'b0;
        spi_bits(8'h8A, 7, got);
        frame_end();
        chk("coinc_advs", adv_cnt - n0, 32'd1);
        chk("coinc_recv", {24'd0, rx_log[$]}, 32'hC5);

        // Abort after five rises, then a clean frame.
        tx_q.push_back(8'h00);
        repeat (3) @(posedge Clk);
        n0 = adv_cnt;
        frame_start();
        spi_bits(8'hFF, 5, got);
        #(HALF);
        chk("abort_miso_low", {31'd0, MISO}, 32'd0);
        SCE = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
        chk("abort_miso_high", {31'd0, MISO}, 32'd1);
        #(4*HALF);
        chk("abort_no_adv", adv_cnt - n0, 32'd0);
        frame_start();
        spi_bits(8'h5A, 8, got);
        frame_end();
        chk("after_abort_advs", adv_cnt - n0, 32'd1);
        chk("after_abort_recv", {24'd0, rx_log[$]}, 32'h5A);
        chk("after_abort_miso", {24'd0, got}, 32'hFF);

        // Two bytes with no acknowledge: second overwrites the first.
        auto_ack = 1'b0;
        frame_start();
        spi_bits(8'h12, 8, got);
        spi_bits(8'h34, 8, got);
        frame_end();
        chk("ovr_recvdata", {24'd0, RecvData}, 32'h34);
        chk("ovr_recvadv", {31'd0, RecvAdv}, 32'd1);
`ifdef SPI_SLAVE_OVERRUN_EN
        chk("ovr_flag_set", {31'd0, Overrun}, 32'd1);
`endif
        ack_req_cnt++;
        repeat (4) @(posedge Clk);
        #1;
        chk("ovr_adv_clear", {31'd0, RecvAdv}, 32'd0);
`ifdef SPI_SLAVE_OVERRUN_EN
        chk("ovr_flag_clear", {31'd0, Overrun}, 32'd0);
`endif
        auto_ack = 1'b1;

        // Asynchronous reset after three rises.
        tx_q.push_back(8'h00);
        repeat (3) @(posedge Clk);
        frame_start();
        spi_bits(8'hFF, 3, got);
        #(HALF/2);
        chk("rstmid_pre_miso", {31'd0, MISO}, 32'd0);
        nReset = 1'b0;
        #1;
        chk("rstmid_miso", {31'd0, MISO}, 32'd1);
        chk("rstmid_sendack", {31'd0, SendAck}, 32'd0);
        chk("rstmid_recvdata", {24'd0, RecvData}, 32'h00);
        chk("rstmid_recvadv", {31'd0, RecvAdv}, 32'd0);
        SCE = 1'b1;
        #50;
        nReset = 1'b1;
        tx_q.push_back(8'h3C);
        repeat (5) @(posedge Clk);
        n0 = adv_cnt;
        frame_start();
        spi_bits(8'hC3, 8, got);
        frame_end();
        chk("rstmid_next_miso", {24'd0, got}, 32'h3C);
        chk("rstmid_next_advs", adv_cnt - n0, 32'd1);
        chk("rstmid_next_recv", {24'd0, rx_log[$]}, 32'hC3);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
